// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the multicycle instruction sequencer:
// state encoding, WriteEn bit positions and the default halt opcode.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam int WE_REG     = 6;
  localparam int WE_MARY    = 5;
  localparam int WE_SHELLEY = 4;
  localparam int WE_COMP    = 3;
  localparam int WE_RA      = 2;
  localparam int WE_PC      = 1;
  localparam int WE_SP      = 0;

  localparam logic [4:0] HALT_OP_DEFAULT = 5'b11111;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expired flags the wait cycle that brings the
// count up to the limit.
module mem_wait_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         count,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt_r;

  // wait-cycle counter, held at zero while clear is asserted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (clear) begin
      cnt_r <= {W{1'b0}};
    end else if (count) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = count && (cnt_r == (limit - W'(1)));

endmodule

// File: rtl/instr_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer: drives the memory handshake
// and gates the control unit's write enables to a single writeback cycle.
module instr_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int         MEM_TIMEOUT = 16,
  parameter int         RC_W        = 16,
  parameter logic [4:0] HALT_OP     = HALT_OP_DEFAULT
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Run,
  input  logic            Stop,
  input  logic [4:0]      OPCODE,
  input  logic            flagbit,
  input  logic            CuMemRead,
  input  logic            CuMemWrite,
  input  logic [WE_REG:0] CuWriteEn,
  input  logic            MemReady,
  output logic            IRWrite,
  output logic            PCIncr,
  output logic            MemReq,
  output logic            MemWe,
  output logic [WE_REG:0] WriteEn,
  output logic [2:0]      State,
  output logic            Halted,
  output logic            Fault,
  output logic [RC_W-1:0] RetireCount
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_t          state_r, state_s;
  logic            fault_r, set_fault_s;
  logic            tmr_clear_s, tmr_count_s, tmr_expired_s;
  logic [RC_W-1:0] rc_r;
  logic            unused_s;

  assign unused_s = flagbit;

  mem_wait_timer #(.W(TW)) u_timer (
    .clk     (CLK),
    .rst     (Reset),
    .clear   (tmr_clear_s),
    .count   (tmr_count_s),
    .limit   (TW'(MEM_TIMEOUT)),
    .expired (tmr_expired_s)
  );

  // next-state and output decode; completion takes priority over timeout
  always_comb begin
    state_s     = state_r;
    set_fault_s = 1'b0;
    tmr_clear_s = 1'b1;
    tmr_count_s = 1'b0;
    IRWrite     = 1'b0;
    PCIncr      = 1'b0;
    MemReq      = 1'b0;
    MemWe       = 1'b0;
    WriteEn     = {(WE_REG+1){1'b0}};
    Halted      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Run) state_s = ST_FETCH;
        else     state_s = ST_IDLE;
      end
      ST_FETCH: begin
        MemReq      = 1'b1;
        IRWrite     = MemReady;
        PCIncr      = MemReady;
        tmr_clear_s = 1'b0;
        tmr_count_s = !MemReady;
        if (MemReady) begin
          state_s = ST_DECODE;
        end else if (tmr_expired_s) begin
          state_s     = ST_HALT;
          set_fault_s = 1'b1;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (OPCODE == HALT_OP) state_s = ST_HALT;
        else                   state_s = ST_EXEC;
      end
      ST_EXEC: begin
        if (CuMemRead || CuMemWrite) state_s = ST_MEM;
        else                         state_s = ST_WB;
      end
      ST_MEM: begin
        MemReq      = 1'b1;
        MemWe       = CuMemWrite;
        tmr_clear_s = 1'b0;
        tmr_count_s = !MemReady;
        if (MemReady) begin
          state_s = ST_WB;
        end else if (tmr_expired_s) begin
          state_s     = ST_HALT;
          set_fault_s = 1'b1;
        end else begin
          state_s = ST_MEM;
        end
      end
      ST_WB: begin
        WriteEn = CuWriteEn;
        if (Stop) state_s = ST_IDLE;
        else      state_s = ST_FETCH;
      end
      ST_HALT: begin
        Halted  = 1'b1;
        state_s = ST_HALT;
      end
      default: begin
        state_s     = ST_HALT;
        set_fault_s = 1'b1;
      end
    endcase
  end

  // state, sticky fault and retire counter
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      fault_r <= 1'b0;
      rc_r    <= {RC_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (set_fault_s) fault_r <= 1'b1;
      else             fault_r <= fault_r;
      if (state_r == ST_WB) rc_r <= rc_r + RC_W'(1);
      else                  rc_r <= rc_r;
    end
  end

  assign State       = state_r;
  assign Fault       = fault_r;
  assign RetireCount = rc_r;

endmodule
